tx_frame_sequencer: RTL

//  Sequences one PICC->PCD frame into bit_encoder: waits the frame delay time (FDT) after start, then

---
 rtl/tx_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tx_frame_sequencer
//
// Sequences one PICC->PCD frame into bit_encoder. After a start pulse it waits
// the frame delay time (FDT_0 or FDT_1 ticks, chosen by the last received PCD
// bit), then raises the encoder enable and supplies SOF (1), the data bits LSB
// first with an odd parity bit after every full byte, and finally drops the
// enable at the end of the last bit period (EOF = no modulation).
//
// Bits advance only on enc_req (encoder count 64), so enc_data changes in the
// middle of a bit period and is stable at the encoder's next count 0.
//
// Ports
//   clk          in   13.56 MHz clock
//   rst_n        in   asynchronous active-low reset
//   start        in   pulse: begin frame (ignored unless idle)
//   last_rx_bit  in   sampled with start: 1 -> FDT_1, 0 -> FDT_0
//   in_data      in   [7:0] next byte to send
//   in_bits      in   [2:0] valid bits of in_data when in_last (0 = full byte)
//   in_last      in   in_data is the final byte of the frame
//   in_valid     in   in_data/in_bits/in_last valid
//   in_ready     out  byte consumed this cycle (combinational handshake)
//   enc_en       out  bit_encoder enable
//   enc_data     out  bit_encoder data bit
//   enc_req      in   bit_encoder request (count == 64)
//   enc_last     in   bit_encoder last tick (count == 127)
//   busy         out  high from start accepted until frame complete
//   done         out  1-cycle pulse: frame complete
//   underrun     out  1-cycle pulse: byte needed but in_valid low
//
// Build option
//   TX_SEQ_ABORT_EN  adds input abort: any non-idle state returns to idle on
//                    the next edge with enc_en/busy low and no done pulse.
// -----------------------------------------------------------------------------
module tx_frame_sequencer #(
  parameter int unsigned FDT_0 = 1172,
  parameter int unsigned FDT_1 = 1236
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       last_rx_bit,
  input  logic [7:0] in_data,
  input  logic [2:0] in_bits,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       enc_en,
  output logic       enc_data,
  input  logic       enc_req,
  input  logic       enc_last,
  output logic       busy,
  output logic       done,
  output logic       underrun
`ifdef TX_SEQ_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int unsigned FDT_MAX = (FDT_0 > FDT_1) ? FDT_0 : FDT_1;
  localparam int unsigned CNT_W   = (FDT_MAX > 1) ? $clog2(FDT_MAX) : 1;

  // The counter is loaded with FDT-1 so enc_en rises exactly FDT edges after
  // the edge that accepted start.
  localparam logic [CNT_W-1:0] FDT0_LOAD = CNT_W'(FDT_0 - 1);
  localparam logic [CNT_W-1:0] FDT1_LOAD = CNT_W'(FDT_1 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FDT,
    S_SOF,
    S_DATA,
    S_PARITY,
    S_FINISH
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] fdt_cnt_q,   fdt_cnt_d;
  logic [7:0]       shift_q,     shift_d;      // remaining bits, current bit in [0]
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [2:0]       last_idx_q,  last_idx_d;   // index of the byte's final data bit
  logic             last_byte_q, last_byte_d;
  logic             has_par_q,   has_par_d;    // full byte -> parity bit follows
  logic             par_q,       par_d;        // odd parity of the loaded byte
  logic             enc_en_q,    enc_en_d;
  logic             enc_data_q,  enc_data_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             underrun_q,  underrun_d;
  logic             load_byte;
  logic             partial;

  // A partial byte can only be the last one, and it carries no parity.
  assign partial = in_last && (in_bits != 3'd0);

  // NOTE: every register below is written with <= so all of them update from
  // the same pre-edge values; blocking = here would create order-dependent
  // behaviour between statements and simulation/synthesis mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fdt_cnt_q   <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      last_idx_q  <= '0;
      last_byte_q <= 1'b0;
      has_par_q   <= 1'b0;
      par_q       <= 1'b0;
      enc_en_q    <= 1'b0;
      enc_data_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fdt_cnt_q   <= fdt_cnt_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      last_idx_q  <= last_idx_d;
      last_byte_q <= last_byte_d;
      has_par_q   <= has_par_d;
      par_q       <= par_d;
      enc_en_q    <= enc_en_d;
      enc_data_q  <= enc_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    // NOTE: each signal assigned here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    fdt_cnt_d   = fdt_cnt_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    last_idx_d  = last_idx_q;
    last_byte_d = last_byte_q;
    has_par_d   = has_par_q;
    par_d       = par_q;
    enc_en_d    = enc_en_q;
    enc_data_d  = enc_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    in_ready    = 1'b0;
    load_byte   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          fdt_cnt_d = last_rx_bit ? FDT1_LOAD : FDT0_LOAD;
          busy_d    = 1'b1;
          state_d   = S_WAIT_FDT;
        end
      end

      S_WAIT_FDT: begin
        if (fdt_cnt_q == '0) begin
          enc_en_d   = 1'b1;
          enc_data_d = 1'b1;          // SOF
          state_d    = S_SOF;
        end else begin
          fdt_cnt_d = fdt_cnt_q - 1'b1;
        end
      end

      S_SOF: begin
        if (enc_req) load_byte = 1'b1;
      end

      S_DATA: begin
        if (enc_req) begin
          if (bit_idx_q == last_idx_q) begin
            if (has_par_q) begin
              enc_data_d = par_q;
              state_d    = S_PARITY;
            end else begin
              // Final bit of a partial byte: it keeps running to enc_last.
              state_d = S_FINISH;
            end
          end else begin
            bit_idx_d  = bit_idx_q + 1'b1;
            shift_d    = shift_q >> 1;
            enc_data_d = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (enc_req) begin
          if (last_byte_q) state_d = S_FINISH;
          else             load_byte = 1'b1;
        end
      end

      S_FINISH: begin
        // Dropping en on the encoder's last tick restarts its counter at 0
        // with en low, so no further bit is sampled.
        if (enc_last) begin
          enc_en_d   = 1'b0;
          enc_data_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Byte boundary: either take the next byte or end the frame on the bit
    // that is currently being sent.
    if (load_byte) begin
      if (in_valid) begin
        in_ready    = 1'b1;
        shift_d     = in_data;
        enc_data_d  = in_data[0];
        bit_idx_d   = 3'd0;
        last_idx_d  = partial ? (in_bits - 3'd1) : 3'd7;
        last_byte_d = in_last;
        has_par_d   = !partial;
        par_d       = ~^in_data;
        state_d     = S_DATA;
      end else begin
        underrun_d = 1'b1;
        state_d    = S_FINISH;
      end
    end

`ifdef TX_SEQ_ABORT_EN
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      fdt_cnt_d  = '0;
      enc_en_d   = 1'b0;
      enc_data_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      in_ready   = 1'b0;
    end
`endif
  end

  assign enc_en   = enc_en_q;
  assign enc_data = enc_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule
